slowctrl_sched: RTL and testbench

Command scheduler in front of panda_slowctrl. It shares the single slow-FPGA serial link between two requesters:
- a host register-write channel, buffered in a small FIFO;
- a periodic status poller that walks a block of slow-FPGA addresses.

It issues one command at a time on panda_slowctrl's wr_req/adr/dat interface and paces commands using busy_o.

---
 rtl/slowctrl_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_slowctrl_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slowctrl_sched.sv
// Command scheduler sharing the panda_slowctrl serial link between a buffered
// host write channel and a periodic status poller; one command in flight at a time.
module slowctrl_sched #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] POLL_BASE  = 10'h200,
    parameter int         POLL_N     = 8,
    parameter int         GAP_CYCLES = 16,
    parameter int         BUSY_WAIT  = 4,
    parameter int         MAX_HOST   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        host_wr_i,
    input  logic [9:0]  host_adr_i,
    input  logic [31:0] host_dat_i,
    output logic        host_full_o,
    output logic        host_drop_o,
    input  logic        poll_en_i,
    input  logic [31:0] poll_period_i,
    output logic        poll_overrun_o,
    output logic        slow_wr_req_o,
    output logic [9:0]  slow_wr_adr_o,
    output logic [31:0] slow_wr_dat_o,
    input  logic        slow_busy_i,
    output logic        timeout_o,
    output logic        idle_o
);

    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PIW       = (POLL_N > 1) ? $clog2(POLL_N) : 1;
    localparam int HCW       = $clog2(MAX_HOST + 1);
    localparam int BWW       = $clog2(BUSY_WAIT + 1);
    localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GW        = $clog2(GAP_LAST + 2);
    localparam int BUSY_LAST = BUSY_WAIT - 1;
    localparam int POLL_LAST = POLL_N - 1;

    localparam logic [AW:0]    DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [HCW-1:0] MAX_C   = MAX_HOST[HCW-1:0];
    localparam logic [BWW-1:0] BLAST_C = BUSY_LAST[BWW-1:0];
    localparam logic [GW-1:0]  GLAST_C = GAP_LAST[GW-1:0];
    localparam logic [PIW-1:0] PLAST_C = POLL_LAST[PIW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [41:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PIW-1:0] poll_idx_q, poll_idx_d;
    logic [31:0]    poll_cnt_q, poll_cnt_d;
    logic           poll_pending_q, poll_pending_d;
    logic [HCW-1:0] host_cnt_q, host_cnt_d;
    logic [BWW-1:0] wb_cnt_q, wb_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           req_q, req_d;
    logic [9:0]     adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic           drop_q, drop_d;
    logic           overrun_q, overrun_d;
    logic           timeout_q, timeout_d;
    logic           idle_q, idle_d;

    logic        fifo_full, fifo_empty, push, pop, tick, go, sel_poll, poll_issue;
    logic [41:0] head;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
    assign fifo_full  = (fifo_cnt_q == DEPTH_C);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = host_wr_i && !fifo_full;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        poll_idx_d     = poll_idx_q;
        poll_cnt_d     = poll_cnt_q;
        poll_pending_d = poll_pending_q;
        host_cnt_d     = host_cnt_q;
        wb_cnt_d       = wb_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        adr_d          = adr_q;
        dat_d          = dat_q;
        req_d          = 1'b0;
        timeout_d      = 1'b0;
        pop            = 1'b0;
        tick           = 1'b0;
        drop_d         = host_wr_i && fifo_full;

        if (poll_en_i && (poll_period_i != 32'd0)) begin
            if (poll_cnt_q >= poll_period_i - 32'd1) begin
                poll_cnt_d = 32'd0;
                tick       = 1'b1;
            end else begin
                poll_cnt_d = poll_cnt_q + 32'd1;
            end
        end else begin
            poll_cnt_d = 32'd0;
        end

        sel_poll   = poll_pending_q && (fifo_empty || (host_cnt_q >= MAX_C));
        go         = (state_q == S_IDLE) && !slow_busy_i && (poll_pending_q || !fifo_empty);
        poll_issue = go && sel_poll;

        // The command is latched on the edge entering ISSUE so req/adr/dat appear together.
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ISSUE;
                    req_d   = 1'b1;
                    if (sel_poll) begin
                        adr_d      = POLL_BASE + {{(10-PIW){1'b0}}, poll_idx_q};
                        dat_d      = 32'd0;
                        poll_idx_d = (poll_idx_q == PLAST_C) ? '0 : poll_idx_q + PIW'(1);
                        host_cnt_d = '0;
                    end else begin
                        adr_d = head[41:32];
                        dat_d = head[31:0];
                        pop   = 1'b1;
                        if (host_cnt_q != MAX_C) host_cnt_d = host_cnt_q + HCW'(1);
                    end
                end else if (fifo_empty) begin
                    host_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT_BUSY;
                wb_cnt_d = BWW'(1);
            end
            S_WAIT_BUSY: begin
                if (slow_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (wb_cnt_q >= BLAST_C) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    wb_cnt_d = wb_cnt_q + BWW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!slow_busy_i) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GLAST_C) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A tick coinciding with a poll issue re-arms the request rather than overrunning.
        poll_pending_d = tick ? 1'b1 : (poll_issue ? 1'b0 : poll_pending_q);
        overrun_d      = tick && poll_pending_q && !poll_issue;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        fifo_cnt_d = fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);

        idle_d = (state_d == S_IDLE) && (fifo_cnt_d == '0) && !poll_pending_d;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {host_adr_i, host_dat_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            poll_idx_q     <= '0;
            poll_cnt_q     <= 32'd0;
            poll_pending_q <= 1'b0;
            host_cnt_q     <= '0;
            wb_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            req_q          <= 1'b0;
            adr_q          <= 10'd0;
            dat_q          <= 32'd0;
            drop_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            idle_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            poll_idx_q     <= poll_idx_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
            host_cnt_q     <= host_cnt_d;
            wb_cnt_q       <= wb_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            req_q          <= req_d;
            adr_q          <= adr_d;
            dat_q          <= dat_d;
            drop_q         <= drop_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            idle_q         <= idle_d;
        end
    end

    assign host_full_o    = fifo_full;
    assign host_drop_o    = drop_q;
    assign poll_overrun_o = overrun_q;
    assign slow_wr_req_o  = req_q;
    assign slow_wr_adr_o  = adr_q;
    assign slow_wr_dat_o  = dat_q;
    assign timeout_o      = timeout_q;
    assign idle_o         = idle_q;

endmodule

// File: tb/tb_slowctrl_sched.sv
// Bench for slowctrl_sched: scoreboard of expected commands checked against every
// slow_wr_req_o, with a simple panda_slowctrl busy model.
module tb_slowctrl_sched;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        host_wr_i = 1'b0;
    logic [9:0]  host_adr_i = 10'd0;
    logic [31:0] host_dat_i = 32'd0;
    logic        host_full_o, host_drop_o;
    logic        poll_en_i = 1'b0;
    logic [31:0] poll_period_i = 32'd0;
    logic        poll_overrun_o;
    logic        slow_wr_req_o;
    logic [9:0]  slow_wr_adr_o;
    logic [31:0] slow_wr_dat_o;
    logic        slow_busy_i;
    logic        timeout_o, idle_o;
    logic        busy_m = 1'b0, busy_force = 1'b0;

    always #5 clk = ~clk;
    assign slow_busy_i = busy_m | busy_force;

    slowctrl_sched #(
        .FIFO_DEPTH(4), .POLL_BASE(10'h200), .POLL_N(8),
        .GAP_CYCLES(GAP), .BUSY_WAIT(4), .MAX_HOST(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .host_wr_i(host_wr_i), .host_adr_i(host_adr_i), .host_dat_i(host_dat_i),
        .host_full_o(host_full_o), .host_drop_o(host_drop_o),
        .poll_en_i(poll_en_i), .poll_period_i(poll_period_i), .poll_overrun_o(poll_overrun_o),
        .slow_wr_req_o(slow_wr_req_o), .slow_wr_adr_o(slow_wr_adr_o), .slow_wr_dat_o(slow_wr_dat_o),
        .slow_busy_i(slow_busy_i), .timeout_o(timeout_o), .idle_o(idle_o)
    );

    typedef struct packed {
        logic [9:0]  adr;
        logic [31:0] dat;
    } cmd_t;

    typedef struct {
        logic [9:0]  adr;
        logic [31:0] dat;
        logic        acc;
        logic        exp_full;
        logic        exp_drop;
    } vec_t;

    cmd_t sb[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, req_cnt = 0, last_req_cyc = -1000, last_fall_cyc = -1000, last_rst_cyc = 0;
    int timeout_cnt = 0, last_to_cyc = -1000, overrun_cnt = 0, drop_cnt = 0;
    int busy_len = 5;
    bit busy_never = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: scoreboard compare on each command, event counters.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (slow_wr_req_o === 1'b1) begin
                if (last_fall_cyc > last_req_cyc && last_req_cyc > last_rst_cyc)
                    chk("issue_gap", 64'((cyc - last_fall_cyc) >= GAP), 64'd1);
                req_cnt++;
                last_req_cyc = cyc;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_issue: adr %0h dat %0h, nothing expected",
                             slow_wr_adr_o, slow_wr_dat_o);
                end else begin
                    e = sb.pop_front();
                    chk("issue_adr", 64'(slow_wr_adr_o), 64'(e.adr));
                    chk("issue_dat", 64'(slow_wr_dat_o), 64'(e.dat));
                end
            end
            if (timeout_o === 1'b1) begin
                timeout_cnt++;
                last_to_cyc = cyc;
            end
            if (poll_overrun_o === 1'b1) overrun_cnt++;
            if (host_drop_o === 1'b1) drop_cnt++;
        end
    end

    // panda_slowctrl model: busy rises half a clock after the strobe, held busy_len clocks.
    initial forever begin
        @(negedge clk);
        if (slow_wr_req_o === 1'b1 && !busy_never) begin
            busy_m = 1'b1;
            repeat (busy_len) @(negedge clk);
            busy_m = 1'b0;
            last_fall_cyc = cyc;
        end
    end

    task automatic wait_req(input int target, input int budget, input string name);
        int n = 0;
        while (req_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_req_seen"}, 64'(req_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (idle_o !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, 64'(idle_o), 64'd1);
    endtask

    task automatic host_write(input logic [9:0] a, input logic [31:0] d);
        host_wr_i = 1'b1; host_adr_i = a; host_dat_i = d;
        @(posedge clk); #1;
        host_wr_i = 1'b0;
    endtask

    task automatic check_reset_out(input string name);
        chk({name, "_req"},     64'(slow_wr_req_o),  64'd0);
        chk({name, "_adr"},     64'(slow_wr_adr_o),  64'd0);
        chk({name, "_dat"},     64'(slow_wr_dat_o),  64'd0);
        chk({name, "_full"},    64'(host_full_o),    64'd0);
        chk({name, "_drop"},    64'(host_drop_o),    64'd0);
        chk({name, "_overrun"}, 64'(poll_overrun_o), 64'd0);
        chk({name, "_timeout"}, 64'(timeout_o),      64'd0);
        chk({name, "_idle"},    64'(idle_o),         64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_i = 1'b1; host_wr_i = 1'b0; poll_en_i = 1'b0; poll_period_i = 32'd0;
        busy_force = 1'b0; busy_never = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        last_rst_cyc = cyc;
    endtask

    initial begin
        vec_t vt[5];
        int t0, base, prev, c0, ov0, to0, n;

        vt[0] = '{10'h355, 32'h0000_0355, 1'b1, 1'b0, 1'b0};
        vt[1] = '{10'h356, 32'h0000_0356, 1'b1, 1'b0, 1'b0};
        vt[2] = '{10'h357, 32'h0000_0357, 1'b1, 1'b0, 1'b0};
        vt[3] = '{10'h358, 32'h0000_0358, 1'b1, 1'b1, 1'b0};
        vt[4] = '{10'h359, 32'h0000_0359, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_reset_out("reset");
        reset_i = 1'b0;
        last_rst_cyc = cyc;

        // 1: single host write, latency and post-busy gap
        busy_len = 37;
        base = req_cnt;
        @(posedge clk); #1;
        t0 = cyc;
        sb.push_back('{10'h3AA, 32'h55AA_55AA});
        host_write(10'h3AA, 32'h55AA_55AA);
        wait_req(base + 1, 20, "t1_first");
        chk("t1_latency", 64'(last_req_cyc - t0), 64'd2);
        n = 0;
        while (!(last_fall_cyc > last_req_cyc) && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t1_busy_fell", 64'(last_fall_cyc > last_req_cyc), 64'd1);
        sb.push_back('{10'h3AB, 32'h1234_5678});
        host_write(10'h3AB, 32'h1234_5678);
        wait_req(base + 2, 40, "t1_second");
        wait_idle(100, "t1");
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: five back-to-back writes into a depth-4 FIFO while the link is busy
        do_reset();
        busy_len = 5;
        busy_force = 1'b1;
        base = req_cnt;
        c0 = drop_cnt;
        for (int i = 0; i < 5; i++) begin
            if (vt[i].acc) sb.push_back('{vt[i].adr, vt[i].dat});
            host_wr_i = 1'b1; host_adr_i = vt[i].adr; host_dat_i = vt[i].dat;
            @(posedge clk); #1;
            chk($sformatf("t2_full_%0d", i), 64'(host_full_o), 64'(vt[i].exp_full));
            chk($sformatf("t2_drop_%0d", i), 64'(host_drop_o), 64'(vt[i].exp_drop));
        end
        host_wr_i = 1'b0;
        busy_force = 1'b0;
        wait_req(base + 4, 200, "t2_drain");
        wait_idle(60, "t2");
        chk("t2_drop_count", 64'(drop_cnt - c0), 64'd1);
        chk("t2_full_clear", 64'(host_full_o), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: poll walk with wrap, one issue per period
        do_reset();
        busy_len = 20;
        for (int i = 0; i < 9; i++) sb.push_back('{10'(32'h200 + (i % 8)), 32'd0});
        base = req_cnt;
        poll_period_i = 32'd100;
        poll_en_i = 1'b1;
        wait_req(base + 1, 150, "t3_first");
        prev = last_req_cyc;
        for (int i = 1; i < 9; i++) begin
            wait_req(base + i + 1, 150, "t3_poll");
            chk($sformatf("t3_period_%0d", i), 64'(last_req_cyc - prev), 64'd100);
            prev = last_req_cyc;
        end
        poll_en_i = 1'b0;
        wait_idle(60, "t3");
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: poll starvation limit under continuous host traffic
        do_reset();
        busy_len = 5;
        busy_force = 1'b1;
        poll_period_i = 32'd5;
        poll_en_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        poll_en_i = 1'b0;
        chk("t4_pending_not_idle", 64'(idle_o), 64'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 8) sb.push_back('{10'h200, 32'd0});
            sb.push_back('{10'(32'h100 + i), 32'hA000_0000 + 32'(i)});
        end
        base = req_cnt;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) busy_force = 1'b0;
            n = 0;
            while (host_full_o === 1'b1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            host_write(10'(32'h100 + i), 32'hA000_0000 + 32'(i));
        end
        wait_req(base + 13, 800, "t4_all");
        wait_idle(60, "t4");
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: overruns while the link is held busy, then a single poll
        do_reset();
        busy_len = 5;
        busy_force = 1'b1;
        ov0 = overrun_cnt;
        poll_period_i = 32'd10;
        poll_en_i = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        poll_en_i = 1'b0;
        busy_force = 1'b0;
        sb.push_back('{10'h200, 32'd0});
        base = req_cnt;
        repeat (100) @(posedge clk);
        #1;
        chk("t5_overruns", 64'(overrun_cnt - ov0), 64'd19);
        chk("t5_one_poll", 64'(req_cnt - base), 64'd1);
        chk("t5_idle", 64'(idle_o), 64'd1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // 6: busy never rises -> timeout; then reset in WAIT_DONE
        do_reset();
        busy_never = 1'b1;
        to0 = timeout_cnt;
        base = req_cnt;
        sb.push_back('{10'h3C0, 32'hDEAD_BEEF});
        host_write(10'h3C0, 32'hDEAD_BEEF);
        wait_req(base + 1, 20, "t6_first");
        t0 = last_req_cyc;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_timeout_count", 64'(timeout_cnt - to0), 64'd1);
        chk("t6_timeout_latency", 64'(last_to_cyc - t0), 64'd4);
        wait_idle(40, "t6");
        busy_never = 1'b0;
        busy_len = 40;
        sb.push_back('{10'h3C1, 32'hCAFE_F00D});
        host_write(10'h3C1, 32'hCAFE_F00D);
        wait_req(base + 2, 60, "t6_second");
        repeat (5) @(posedge clk);
        #1;
        chk("t6_in_wait_done", 64'(idle_o), 64'd0);
        reset_i = 1'b1;
        @(posedge clk); #1;
        check_reset_out("t6_reset");
        reset_i = 1'b0;
        last_rst_cyc = cyc;
        repeat (50) @(posedge clk);
        #1;
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        chk("total_drops", 64'(drop_cnt), 64'd1);
        chk("total_timeouts", 64'(timeout_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
